// File: rtl/gauss3x3_add_sched.sv
// gauss3x3_add_sched: 3x3 Gaussian filter, one tap per clock through a shared FA-cell adder; GAUSS_ROUND_EN selects round-half-up output
module gauss3x3_add_sched #(
  parameter int DATA_W = 8,
  parameter int ACC_W = DATA_W + 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [9*DATA_W-1:0]   in_win,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_W-1:0]     out_pix,
  output logic                  busy
);
`ifdef GAUSS_ROUND_EN
  localparam logic [ACC_W-1:0] ACC_INIT = ACC_W'(8);
`else
  localparam logic [ACC_W-1:0] ACC_INIT = '0;
`endif
  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;
  state_t state, nxt;
  logic [DATA_W-1:0] win [9];
  logic [DATA_W-1:0] tap;
  logic [3:0] tap_cnt;
  logic [1:0] sh;
  logic [ACC_W-1:0] acc, op, s, c;
  logic accept;
  assign accept = (state == IDLE) && in_valid;
  assign in_ready = state == IDLE;
  assign busy = state != IDLE;
  assign out_valid = state == DONE;
  assign out_pix = acc[ACC_W-1:4];
  // state register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= nxt;
  // next state: nine adds, then hold the result until downstream takes it
  always_comb begin
    nxt = IDLE;
    nxt = state == IDLE  ? (in_valid ? ACCUM : IDLE) :
          state == ACCUM ? (tap_cnt == 4'd8 ? DONE : ACCUM) :
          state == DONE  ? (out_ready ? IDLE : DONE) : IDLE;
  end
  // window capture on accept; contents are don't-care until the first accept
  always_ff @(posedge clk)
    if (accept) for (int k = 0; k < 9; k++) win[k] <= in_win[k*DATA_W +: DATA_W];
  // select current tap and its weight shift: corners x1, edges x2, centre x4
  always_comb begin
    tap = (tap_cnt < 4'd9) ? win[tap_cnt] : '0;
    sh = tap_cnt == 4'd4 ? 2'd2 :
         (tap_cnt == 4'd0 || tap_cnt == 4'd2 || tap_cnt == 4'd6 || tap_cnt == 4'd8) ? 2'd0 : 2'd1;
    op = {{(ACC_W-DATA_W){1'b0}}, tap} << sh;
  end
  assign c[0] = 1'b0;
  genvar i;
  generate
    for (i = 0; i < ACC_W; i++) begin : g_fa
      assign s[i] = acc[i] ^ op[i] ^ c[i];
      if (i < ACC_W - 1) begin : g_c
        assign c[i+1] = (acc[i] & op[i]) | (c[i] & (acc[i] ^ op[i]));
      end
    end
  endgenerate
  // accumulator and tap counter
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      acc <= '0;
      tap_cnt <= '0;
    end else if (accept) begin
      acc <= ACC_INIT;
      tap_cnt <= '0;
    end else if (state == ACCUM) begin
      acc <= s;
      tap_cnt <= tap_cnt + 4'd1;
    end
endmodule

// File: tb/tb_gauss3x3_add_sched.sv
// tb_gauss3x3_add_sched: directed bench with a cycle-level protocol model for gauss3x3_add_sched
module tb_gauss3x3_add_sched;
  localparam int DW = 8;
`ifdef GAUSS_ROUND_EN
  localparam int RND = 8;
`else
  localparam int RND = 0;
`endif
  logic clk = 0, rst_n, in_valid, in_ready, out_valid, out_ready, busy;
  logic [9*DW-1:0] in_win;
  logic [DW-1:0] out_pix;
  int n_chk = 0, n_fail = 0;
  gauss3x3_add_sched dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_win(in_win),
    .out_valid(out_valid), .out_ready(out_ready), .out_pix(out_pix), .busy(busy)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask
  function automatic int gauss(input logic [9*DW-1:0] w);
    int wt [9] = '{1, 2, 1, 2, 4, 2, 1, 2, 1};
    int sum = 0;
    for (int k = 0; k < 9; k++) sum += wt[k] * int'(w[k*DW +: DW]);
    return (sum + RND) >> 4;
  endfunction
  function automatic logic [9*DW-1:0] pk(input int t [9]);
    logic [9*DW-1:0] w;
    for (int k = 0; k < 9; k++) w[k*DW +: DW] = DW'(t[k]);
    return w;
  endfunction
  int ph = 0, left = 0, m_exp = 0;
  always @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      ph <= 0;
      left <= 0;
    end else if (ph == 0 && in_valid) begin
      m_exp <= gauss(in_win);
      left <= 9;
      ph <= 1;
    end else if (ph == 1) begin
      left <= left - 1;
      if (left == 1) ph <= 2;
    end else if (ph == 2 && out_ready) ph <= 0;
  always @(negedge clk) begin
    chk("cyc_out_valid", int'(out_valid), int'(ph == 2));
    chk("cyc_in_ready", int'(in_ready), int'(ph == 0));
    chk("cyc_busy", int'(busy), int'(ph != 0));
    if (ph == 2) chk("cyc_out_pix", int'(out_pix), m_exp);
  end
  task automatic accept(input logic [9*DW-1:0] w);
    in_valid = 1;
    in_win = w;
    @(posedge clk); #1;
    in_valid = 0;
  endtask
  task automatic wait_out(input string name, input int exp);
    int lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({name, "_latency"}, lat, 9);
    chk({name, "_pix"}, int'(out_pix), exp);
  endtask
  task automatic take;
    out_ready = 1;
    @(posedge clk); #1;
    chk("drop_valid", int'(out_valid), 0);
  endtask
  int t [9];
  logic [9*DW-1:0] w1, w2, w3, w4, w5, w6, w7;
  initial begin
    rst_n = 0; in_valid = 0; out_ready = 1; in_win = '0;
    t = '{255, 255, 255, 255, 255, 255, 255, 255, 255}; w1 = pk(t);
    t = '{0, 0, 0, 0, 16, 0, 0, 0, 0}; w2 = pk(t);
    t = '{10, 20, 30, 40, 50, 60, 70, 80, 90}; w3 = pk(t);
    t = '{8, 0, 0, 0, 0, 0, 0, 0, 0}; w4 = pk(t);
    t = '{16, 16, 16, 16, 16, 16, 16, 16, 16}; w5 = pk(t);
    t = '{32, 32, 32, 32, 32, 32, 32, 32, 32}; w6 = pk(t);
    t = '{100, 100, 100, 100, 100, 100, 100, 100, 100}; w7 = pk(t);
    chk("model_all255", gauss(w1), 255);
    chk("model_centre", gauss(w2), 4);
    chk("model_ramp", gauss(w3), 50);
    chk("model_tap0_8", gauss(w4), RND ? 1 : 0);
    repeat (2) @(posedge clk); #1;
    chk("rst_out_pix", int'(out_pix), 0);
    chk("rst_in_ready", int'(in_ready), 1);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_busy", int'(busy), 0);
    rst_n = 1;
    @(posedge clk); #1;
    accept(w1); wait_out("all255", 255); take;
    accept(w2); wait_out("centre", 4); take;
    accept(w3); wait_out("ramp", 50); take;
    accept(w4); wait_out("tap0_8", RND ? 1 : 0); take;
    out_ready = 0;
    accept(w5); wait_out("hold_first", 16);
    in_valid = 1; in_win = w6;
    repeat (5) begin
      @(posedge clk); #1;
      chk("hold_valid", int'(out_valid), 1);
      chk("hold_pix", int'(out_pix), 16);
      chk("hold_in_ready", int'(in_ready), 0);
    end
    out_ready = 1;
    @(posedge clk); #1;
    chk("release_in_ready", int'(in_ready), 1);
    chk("release_valid", int'(out_valid), 0);
    @(posedge clk); #1;
    in_valid = 0;
    wait_out("second", 32); take;
    accept(w3);
    repeat (4) @(posedge clk);
    #2 rst_n = 0;
    #1;
    chk("abort_out_valid", int'(out_valid), 0);
    chk("abort_in_ready", int'(in_ready), 1);
    chk("abort_busy", int'(busy), 0);
    chk("abort_out_pix", int'(out_pix), 0);
    @(posedge clk); #1;
    rst_n = 1;
    @(posedge clk); #1;
    accept(w7); wait_out("after_abort", 100); take;
    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
